// File: rtl/imm_field_encoder_pkg.sv
// Shared definitions for the immediate field encoder: format codes, field masks,
// field widths and the signed-range helper used by the fit check.
package imm_field_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } fmt_e;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  localparam int unsigned W_I = 12;
  localparam int unsigned W_S = 12;
  localparam int unsigned W_B = 13;
  localparam int unsigned W_U = 20;
  localparam int unsigned W_J = 21;

  // True when imm equals the sign extension of its low n bits: everything from
  // bit n-1 upward must be a copy of the sign.
  function automatic logic fits_signed(input logic signed [31:0] imm,
                                       input int unsigned n);
    logic signed [31:0] hi;
    hi = imm >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational representability check: flags an immediate that cannot be
// encoded in the field of the selected format, or an illegal format code.
module imm_fit_check
  import imm_field_encoder_pkg::*;
(
  input  logic        [2:0]  fmt_i,
  input  logic signed [31:0] imm_i,
  output logic               err_o
);

  always_comb begin
    err_o = 1'b1;
    case (fmt_i)
      FMT_I:   err_o = !fits_signed(imm_i, W_I);
      FMT_S:   err_o = !fits_signed(imm_i, W_S);
      FMT_B:   err_o = !fits_signed(imm_i, W_B) || imm_i[0];
      FMT_U:   err_o = (imm_i[11:0] != 12'h000);
      FMT_J:   err_o = !fits_signed(imm_i, W_J) || imm_i[0];
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Two-stage valid/ready pipeline: stage 1 registers the range check, stage 2
// scatters the immediate into the base word; errored beats pass base through.
module imm_field_encoder
  import imm_field_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic                     vld_p1_q;
  logic [2:0]               fmt_p1_q;
  logic signed [31:0]       imm_p1_q;
  logic [31:0]              base_p1_q;
  logic                     err_p1_q;
  logic                     err_p1_d;

  logic                     vld_p2_q;
  logic [31:0]              inst_p2_q;
  logic [31:0]              inst_p2_d;
  logic                     err_p2_q;

  logic [CNT_W-1:0]         cnt_q;
  logic                     adv_p2;
  logic                     acc_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [31:0] scatter(input logic [2:0]        fmt,
                                          input logic signed [31:0] imm,
                                          input logic [31:0]        base,
                                          input logic               err);
    logic [31:0] mask;
    logic [31:0] field;
    mask  = '0;
    field = '0;
    case (fmt)
      FMT_I: begin mask = MASK_I; field = {imm[11:0], 20'b0}; end
      FMT_S: begin mask = MASK_S; field = {imm[11:5], 13'b0, imm[4:0], 7'b0}; end
      FMT_B: begin mask = MASK_B; field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0}; end
      FMT_U: begin mask = MASK_U; field = {imm[31:12], 12'b0}; end
      FMT_J: begin mask = MASK_J; field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0}; end
      default: ;
    endcase
    return err ? base : ((base & ~mask) | field);
  endfunction

  // Stage 2 advances when empty or drained; stage 1 accepts when it empties into stage 2.
  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p2;
  assign acc_p0   = in_valid && in_ready;

  imm_fit_check u_fit (
    .fmt_i (in_fmt),
    .imm_i (in_imm),
    .err_o (err_p1_d)
  );

  // ---- stage p0 -> p1: range check ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else if (in_ready) begin
      vld_p1_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      fmt_p1_q  <= in_fmt;
      imm_p1_q  <= in_imm;
      base_p1_q <= in_base;
      err_p1_q  <= err_p1_d;
    end
  end

  assign inst_p2_d = scatter(fmt_p1_q, imm_p1_q, base_p1_q, err_p1_q);

  // ---- stage p1 -> p2: scatter into base word ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      inst_p2_q <= '0;
      err_p2_q  <= 1'b0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        inst_p2_q <= inst_p2_d;
        err_p2_q  <= err_p1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (vld_p2_q && out_ready && err_p2_q) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid = vld_p2_q;
  assign out_inst  = inst_p2_q;
  assign out_err   = err_p2_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Randomized scoreboard bench for imm_field_encoder with directed spec vectors,
// backpressure, mid-flight reset and a narrow-counter instance for saturation.
module tb_imm_field_encoder;

  typedef struct {
    logic [31:0] inst;
    bit          err;
    int          fmt;
    logic [31:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [2:0]  in_fmt = 3'd0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_base = '0;
  logic        out_valid, out_valid_s;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst, out_inst_s;
  logic        out_err, out_err_s;
  logic [15:0] err_count;
  logic [2:0]  err_count_s;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;
  int   hold = 0;
  bit   rnd_ready = 1'b0;

  imm_field_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count)
  );

  imm_field_encoder #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_inst(out_inst_s),
    .out_err(out_err_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: representability from numeric ranges, field placement bit by bit.
  function automatic bit model_err(input int f, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (f)
      0, 1:    return !(v >= -2048 && v <= 2047);
      2:       return !(v >= -4096 && v <= 4095) || (v % 2 != 0);
      3:       return (v % 4096 != 0);
      4:       return !(v >= -1048576 && v <= 1048575) || (v % 2 != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] put(input logic [31:0] r, input logic [31:0] imm,
                                      input int ib, input int mb, input int len);
    logic [31:0] o;
    o = r;
    for (int k = 0; k < len; k++) o[ib + k] = imm[mb + k];
    return o;
  endfunction

  function automatic logic [31:0] model_inst(input int f, input logic [31:0] imm,
                                             input logic [31:0] base);
    logic [31:0] r;
    r = base;
    if (model_err(f, imm)) return base;
    case (f)
      0: r = put(r, imm, 20, 0, 12);
      1: r = put(put(r, imm, 25, 5, 7), imm, 7, 0, 5);
      2: r = put(put(put(put(r, imm, 31, 12, 1), imm, 25, 5, 6), imm, 8, 1, 4), imm, 7, 11, 1);
      3: r = put(r, imm, 12, 12, 20);
      4: r = put(put(put(put(r, imm, 31, 20, 1), imm, 21, 1, 10), imm, 20, 11, 1), imm, 12, 12, 8);
      default: r = base;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input int f, input logic [31:0] i);
    case (f)
      0: return {{20{i[31]}}, i[31:20]};
      1: return {{20{i[31]}}, i[31:25], i[11:7]};
      2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3: return {i[31:12], 12'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  task automatic send(input int f, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] xi, input bit xe, output int waits);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_fmt = f[2:0]; in_imm = imm; in_base = base;
    waits = 0;
    while (1) begin
      #1;
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.inst = xi; e.err = xe; e.fmt = f; e.imm = imm;
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand_model(input int f, input logic [31:0] imm, input logic [31:0] base);
    int w;
    send(f, imm, base, model_inst(f, imm, base), model_err(f, imm), w);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", sb_q.size(), 0);
    @(negedge clk); #3;
  endtask

  always @(negedge clk) begin
    if (hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else if (rnd_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: counters every cycle, scoreboard pop on each handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      sb_q.delete();
      exp_cnt = 0;
    end else begin
      chk("err_count", {16'd0, err_count}, (exp_cnt > 65535) ? 32'd65535 : exp_cnt);
      chk("err_count_sat", {29'd0, err_count_s}, (exp_cnt > 7) ? 32'd7 : exp_cnt);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("out_inst", out_inst, e.inst);
          chk("out_err", {31'd0, out_err}, {31'd0, e.err});
          if (!e.err) chk("roundtrip", extract(e.fmt, out_inst), e.imm);
          if (e.err) exp_cnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int w1, w2, w3, w4, f;
    logic [31:0] imm, base;
    int bnd[15] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 0, 1, -1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send(0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0, w1);
    @(negedge clk); #1 chk("latency_n1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1 chk("latency_n2", {31'd0, out_valid}, 32'd1);
    drain();

    send(0, 32'h00000800, 32'h00000013, 32'h00000013, 1'b1, w1);
    send(2, 32'hFFFFFFFE, 32'h00000063, 32'hFE000FE3, 1'b0, w1);
    send(2, 32'h00000003, 32'h00000063, 32'h00000063, 1'b1, w1);
    send(3, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0, w1);
    send(3, 32'h12345001, 32'h00000037, 32'h00000037, 1'b1, w1);
    send(6, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, w1);
    send(4, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0, w1);
    send(1, 32'hFFFFFFFF, 32'h00000023, 32'hFE000FA3, 1'b0, w1);
    drain();

    hold = 3;
    send(0, 32'h00000001, 32'h00000013, 32'h00100013, 1'b0, w1);
    send(0, 32'h00000002, 32'h00000013, 32'h00200013, 1'b0, w2);
    send(0, 32'h00000003, 32'h00000013, 32'h00300013, 1'b0, w3);
    send(0, 32'h00000004, 32'h00000013, 32'h00400013, 1'b0, w4);
    chk("bp_beat1_nowait", w1, 0);
    chk("bp_beat2_nowait", w2, 0);
    chk("bp_beat3_stalled", {31'd0, (w3 > 0)}, 32'd1);
    drain();

    hold = 20;
    send(0, 32'h00001000, 32'h00000013, 32'h00000013, 1'b1, w1);
    send(3, 32'h00000010, 32'h00000037, 32'h00000037, 1'b1, w2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; hold = 0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_err_count", {16'd0, err_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      f = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: imm = bnd[$urandom_range(0, 14)];
        3: imm = $urandom & 32'hFFFFF000;
        4: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      endcase
      base = $urandom;
      send_rand_model(f, imm, base);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rnd_ready = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
